// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM encodings and frame constants for the I2C slave receiver
package i2c_slave_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_STRETCH = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;
  localparam int BYTE_W  = 8;
  localparam int ACK_IDX = 8;
endpackage

// File: rtl/i2c_slave_bus_receiver_filter.sv
// i2c_glitch_filter: synchronises an asynchronous pad line and suppresses pulses shorter than FILTER_LEN
module i2c_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic filt_q, same, hit;
  always_comb begin
    same    = sync_q[SYNC_STAGES-1] == filt_q;
    cnt_inc = cnt_q + 4'd1;
    hit     = !same && cnt_inc == 4'(FILTER_LEN);
    cnt_d   = (same || hit) ? 4'd0 : cnt_inc;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= hit ? ~filt_q : filt_q;
    end
  end
  assign line_o = filt_q;
endmodule

// File: rtl/i2c_slave_bus_receiver.sv
// i2c_slave_bus_receiver: recovers START/STOP and bytes from filtered SCL/SDA, stretching SCL until each byte is taken
module i2c_slave_bus_receiver
  import i2c_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic        i2c_core_clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_rise_o,
  output logic        scl_fall_o,
  output logic        start_o,
  output logic        stop_o,
  output logic        bus_busy_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ack_i,
  output logic        ack_bit_o,
  output logic [3:0]  bit_cnt_o,
  output logic        scl_stretch_o
);
  logic scl_f, sda_f, scl_p_q, sda_p_q, scl_chg;
  logic rise_q, fall_q, start_q, stop_q, rise_d, fall_d, start_d, stop_d;
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d, data_q, data_d;
  logic ack_q, ack_d, valid_q, valid_d, done;
  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i(i2c_core_clk_i), .rst_i(reset_i), .line_i(scl_i), .line_o(scl_f));
  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i(i2c_core_clk_i), .rst_i(reset_i), .line_i(sda_i), .line_o(sda_f));
  // an SDA change coinciding with an SCL change is a data transition, never START/STOP
  always_comb begin
    scl_chg = scl_f ^ scl_p_q;
    rise_d  = en_i & scl_f & ~scl_p_q;
    fall_d  = en_i & ~scl_f & scl_p_q;
    start_d = en_i & ~scl_chg & scl_f & sda_p_q & ~sda_f;
    stop_d  = en_i & ~scl_chg & scl_f & ~sda_p_q & sda_f;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    ack_d   = ack_q;
    done    = 1'b0;
    if (!en_i || stop_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start_q) begin
      state_d = ST_DATA;
      cnt_d   = '0;
    end else if (state_q == ST_DATA) begin
      if (rise_q && cnt_q < 4'(BYTE_W)) begin
        shift_d = {shift_q[BYTE_W-2:0], sda_f};
        cnt_d   = cnt_q + 4'd1;
        done    = cnt_q == 4'(BYTE_W - 1);
      end else if (fall_q && cnt_q == 4'(ACK_IDX))
        state_d = (valid_q && !rx_ack_i) ? ST_STRETCH : ST_ACK;
    end else if (state_q == ST_STRETCH) begin
      state_d = (rx_ack_i || !valid_q) ? ST_ACK : ST_STRETCH;
    end else if (state_q == ST_ACK) begin
      if (rise_q) ack_d = sda_f;
      else if (fall_q) begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
    end
    data_d  = done ? shift_d : data_q;
    valid_d = done | (valid_q & ~rx_ack_i);
  end
  always_ff @(posedge i2c_core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end
  assign scl_rise_o    = rise_q;
  assign scl_fall_o    = fall_q;
  assign start_o       = start_q;
  assign stop_o        = stop_q;
  assign bus_busy_o    = state_q != ST_IDLE;
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign ack_bit_o     = ack_q;
  assign bit_cnt_o     = cnt_q;
  assign scl_stretch_o = state_q == ST_STRETCH;
endmodule

// File: tb/tb_i2c_slave_bus_receiver.sv
// tb_i2c_slave_bus_receiver: I2C master model with wired-AND SCL, byte scoreboard and handshake consumer
module tb_i2c_slave_bus_receiver;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int H  = 20;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, scl_drv = 1'b1, sda = 1'b1;
  logic ignore_st = 1'b0, rx_ack = 1'b0, hold = 1'b0;
  logic scl_pad, scl_rise, scl_fall, start, stop, busy, rx_valid, ack_bit, stretch;
  logic [7:0] rx_data;
  logic [3:0] bit_cnt;
  int checks = 0, passes = 0, cyc = 0, n_start = 0, n_stop = 0;
  int ack_delay = 2, ack_cyc = 0, last_fall = 0, on_gap = -1, off_gap = -1;
  bit saw_stretch = 0, st_prev = 0, v_prev = 0;
  logic [7:0] exp_q[$];

  assign scl_pad = scl_drv & (ignore_st | ~stretch);

  i2c_slave_bus_receiver #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .i2c_core_clk_i(clk), .reset_i(rst), .en_i(en), .scl_i(scl_pad), .sda_i(sda),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start), .stop_o(stop),
    .bus_busy_o(busy), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ack_i(rx_ack),
    .ack_bit_o(ack_bit), .bit_cnt_o(bit_cnt), .scl_stretch_o(stretch));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  initial forever begin
    @(negedge clk);
    if (start) n_start++;
    if (stop) n_stop++;
    if (scl_fall) last_fall = cyc;
    if (stretch && !st_prev) begin saw_stretch = 1; on_gap = cyc - last_fall; end
    if (!stretch && st_prev && !rst) off_gap = cyc - ack_cyc;
    st_prev = stretch;
    if (rx_valid && !v_prev) begin
      if (exp_q.size() == 0) chk("sb_unexpected_byte", 0, 1);
      else chk("sb_rx_data", rx_data, exp_q.pop_front());
    end
    v_prev = rx_valid;
  end

  initial forever begin
    @(negedge clk);
    if (rx_valid && !hold) begin
      repeat (ack_delay) @(negedge clk);
      if (!hold) begin
        rx_ack = 1'b1;
        ack_cyc = cyc;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic hw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pad();
    int n = 0;
    while (!scl_pad && n < 2000) begin @(negedge clk); n++; end
    if (!scl_pad) chk("scl_release_timeout", 0, 1);
  endtask

  task automatic bus_start();
    sda = 1'b1; hw(H);
    scl_drv = 1'b1; wait_pad(); hw(H);
    sda = 1'b0; hw(H);
    scl_drv = 1'b0; hw(H);
  endtask

  task automatic bus_stop();
    sda = 1'b0; hw(H);
    scl_drv = 1'b1; wait_pad(); hw(H);
    sda = 1'b1; hw(H);
  endtask

  task automatic send_bit(input logic b);
    sda = b; hw(H);
    scl_drv = 1'b1; wait_pad(); hw(H);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(a);
  endtask

  initial begin
    int s0, p0, nb;
    logic [7:0] b;
    logic a, lng;
    hw(4);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ack_bit", ack_bit, 1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_stretch", stretch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    rst = 1'b0;
    hw(10);
    // quick ack before the 8th fall: no stretching
    s0 = n_start;
    ack_delay = 2; saw_stretch = 0;
    bus_start();
    chk("t1_start_pulse", n_start, s0 + 1);
    chk("t1_busy", busy, 1);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0);
    chk("t1_stretch_seen", saw_stretch, 0);
    chk("t1_valid_cleared", rx_valid, 0);
    chk("t1_ack_bit", ack_bit, 0);
    bus_stop();
    // withheld ack: stretch from the cycle after the 8th fall until the cycle after ack
    ack_delay = 50; saw_stretch = 0; on_gap = -1; off_gap = -1;
    bus_start();
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    chk("t2_stretch_seen", saw_stretch, 1);
    chk("t2_stretch_on_gap", on_gap, 1);
    chk("t2_stretch_off_gap", off_gap, 1);
    chk("t2_ack_bit", ack_bit, 1);
    bus_stop();
    chk("t2_busy_after_stop", busy, 0);
    // SDA glitches while SCL idles high
    s0 = n_start; p0 = n_stop;
    sda = 1'b0; hw(FL - 1); sda = 1'b1; hw(30);
    chk("t3_short_no_start", n_start, s0);
    chk("t3_short_no_stop", n_stop, p0);
    sda = 1'b0; hw(FL); sda = 1'b1; hw(30);
    chk("t3_long_start", n_start, s0 + 1);
    chk("t3_long_stop", n_stop, p0 + 1);
    // STOP after a partial byte
    ack_delay = 2;
    bus_start();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    chk("t4_bit_cnt5", bit_cnt, 5);
    p0 = n_stop;
    bus_stop();
    chk("t4_stop_pulse", n_stop, p0 + 1);
    chk("t4_busy", busy, 0);
    chk("t4_bit_cnt", bit_cnt, 0);
    chk("t4_valid", rx_valid, 0);
    // repeated START while stretching
    hold = 1'b1;
    bus_start();
    exp_q.push_back(8'h5A);
    for (int i = 7; i >= 0; i--) send_bit(1'((8'h5A >> i) & 8'h01));
    hw(30);
    chk("t5_stretching", stretch, 1);
    s0 = n_start;
    ignore_st = 1'b1;
    bus_start();
    chk("t5_rstart_pulse", n_start, s0 + 1);
    chk("t5_stretch_dropped", stretch, 0);
    chk("t5_bit_cnt", bit_cnt, 0);
    chk("t5_valid_kept", rx_valid, 1);
    hold = 1'b0; ack_delay = 2;
    hw(10);
    chk("t5_valid_acked", rx_valid, 0);
    ignore_st = 1'b0;
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b0);
    chk("t5_ack_bit", ack_bit, 0);
    bus_stop();
    // disable mid-frame
    bus_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    en = 1'b0; hw(3);
    chk("en_busy", busy, 0);
    chk("en_bit_cnt", bit_cnt, 0);
    en = 1'b1;
    bus_stop();
    // randomized frames against the reference: bytes in order, stretch iff ack arrives late
    for (int f = 0; f < 6; f++) begin
      bus_start();
      nb = $urandom_range(1, 2);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        a = 1'($urandom_range(0, 1));
        lng = 1'($urandom_range(0, 1));
        ack_delay = lng ? $urandom_range(40, 60) : $urandom_range(0, 8);
        saw_stretch = 0;
        exp_q.push_back(b);
        send_byte(b, a);
        chk("rnd_ack_bit", ack_bit, a);
        chk("rnd_stretch", saw_stretch, lng);
        chk("rnd_valid_cleared", rx_valid, 0);
      end
      bus_stop();
      chk("rnd_busy_after_stop", busy, 0);
      chk("rnd_bit_cnt_after_stop", bit_cnt, 0);
    end
    // async reset while stretching
    hold = 1'b1;
    bus_start();
    b = 8'($urandom);
    exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    hw(30);
    chk("t6_stretching", stretch, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_stretch", stretch, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_bit_cnt", bit_cnt, 0);
    chk("t6_rst_rx_data", rx_data, 0);
    chk("t6_rst_ack_bit", ack_bit, 1);
    chk("t6_rst_pulses", {scl_rise, scl_fall, start, stop}, 0);
    hw(3);
    rst = 1'b0;
    hold = 1'b0; ack_delay = 2;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    chk("t6_no_recover_cnt", bit_cnt, 0);
    chk("t6_no_recover_busy", busy, 0);
    chk("t6_no_recover_valid", rx_valid, 0);
    bus_start();
    b = 8'($urandom);
    exp_q.push_back(b);
    send_byte(b, 1'b0);
    bus_stop();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
